chol_diag_acc: RTL and testbench
================================

// Module: chol_diag_acc
// PURPOSE
//  Upstream feeder of the Newton-Raphson square-root stage in the Cholesky inverse datapath.
//  - Computes the diagonal residual d_j = a_jj - sum_{k<j} l_jk^2 in signed fixed point.
//  - Streams d_j to the sqrt stage as a 1-cycle valid pulse with no backpressure.
//  - Flags non-positive-definite pivots and clamps them so the sqrt stage never sees a negative input.
// PARAMETERS
//  W       32  data width, signed two's complement
//  FRAC    29  fractional bits; Q(W-FRAC-1).FRAC; matches the sqrt stage scaling
//  N_MAX   7   max number of l_jk terms per pivot
//  ACC_W   40  accumulator width; must be >= 2*W-FRAC+clog2(N_MAX+1)
//  EPS     32'h0000_0400  pivot floor; used only with CHOL_DIAG_EPS_EN
// PORTS
//  clk        in   1      clock; rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin a pivot; sampled only in IDLE
//  a_diag     in   W      a_jj, captured on start
//  n_terms    in   3      number of l_jk terms (0..N_MAX), captured on start
//  l_valid    in   1      l_val valid
//  l_val      in   W      next l_jk, signed
//  l_ready    out  1      term accepted on a cycle where l_valid & l_ready
//  busy       out  1      high in every state except IDLE
//  out_val    out  W      residual, non-negative; drives the sqrt stage in_val
//  out_valid  out  1      1-cycle pulse; drives the sqrt stage in_valid
//  pd_err     out  1      pivot not positive definite; updated with out_valid, held until next result
// BEHAVIOUR
//  Reset: out_val=0, out_valid=0, pd_err=0, l_ready=0, busy=0, acc=0, cnt=0, prod_v=0, state=IDLE.
//  FSM: IDLE -> ACC -> DRAIN -> OUT -> IDLE.
//  - IDLE: on start, latch a_diag and n_terms; clear acc and cnt.
//    -> ACC if n_terms != 0, else -> DRAIN. start is ignored in every other state.
//  - ACC: l_ready = 1. On each accept: prod_r <= l_val*l_val (2W-bit, signed), prod_v <= 1, cnt++.
//    Cycles without an accept set prod_v <= 0. -> DRAIN on the accept that makes cnt == n_terms.
//  - Every state: if prod_v, acc <= acc + (prod_r >>> FRAC). Truncation happens per term. acc is never negative.
//  - DRAIN: last product is absorbed. -> OUT.
//  - OUT: diff = sext(a_diag) - acc, computed in ACC_W+1 bits.
//    Register out_val, pd_err, out_valid=1. -> IDLE.
//  Clamp without CHOL_DIAG_EPS_EN: diff <= 0 -> out_val = 0, pd_err = 1; otherwise out_val = diff[W-1:0], pd_err = 0.
//  diff <= 2^(W-1)-1 always holds because acc >= 0, so no upper saturation is needed.
//  Latency: start sampled at edge 0. With terms back-to-back, accepts occur at edges 1..N.
//    out_valid is high for exactly the cycle after edge N+2 (N=0 gives edge 2).
//    Each input gap adds one cycle.
//  n_terms > N_MAX: treated as N_MAX.
//  l_valid outside ACC: ignored, nothing accepted.
//  start coincident with out_valid: state is OUT, so start is ignored. The source must wait for busy = 0.
//  Async reset mid-operation: immediate return to reset values; no out_valid; the partial pivot is discarded.
//  Product -4.0^2 = 16.0 fits in ACC_W; the N_MAX-term sum is at most 112.0, which also fits.
// CONFIGURATION
//  CHOL_DIAG_EPS_EN defined:
//  - diff < EPS -> out_val = EPS; pd_err = 1 iff diff <= 0.
//  - Guarantees a non-zero pivot so the downstream reciprocal never divides by 0.
//  CHOL_DIAG_EPS_EN undefined: clamp to 0 as above; the EPS parameter is unused.
// TESTING
//  1. a=0x4000_0000 (2.0), N=2, l=0x1000_0000,0x1000_0000 back-to-back
//     -> out_val=0x3000_0000 after edge 4, pd_err=0.
//  2. a=0x2000_0000, N=0 -> out_val=0x2000_0000 after edge 2; l_ready never asserted.
//  3. a=0x1000_0000 (0.5), N=1, l=0x2000_0000 (1.0)
//     -> out_val=0, pd_err=1; with CHOL_DIAG_EPS_EN: out_val=0x0000_0400, pd_err=1.
//  4. a=0x4000_0000, N=3, l=0xF000_0000 (-0.5) x3, l_valid low 2 cycles between terms
//     -> out_val=0x2800_0000 after edge 9; l_valid pulses in IDLE are ignored.
//  5. rst_n low for 1 cycle after 1 of 3 terms accepted
//     -> busy=0, no out_valid; a fresh pivot afterwards (test 1 stimulus) returns 0x3000_0000.
//  6. a=0x7FFF_FFFF, N=7, l=0x8000_0000 x7 -> out_val=0, pd_err=1.
//     start pulsed while busy -> ignored, exactly one out_valid.

Source files
------------

// File: rtl/chol_diag_acc.sv
// Diagonal residual d_j = a_jj - sum(l_jk^2) for the Cholesky sqrt stage, with non-PD clamping.
// Optional macro CHOL_DIAG_EPS_EN: clamp small/negative pivots to EPS instead of 0.
module chol_diag_acc #(
   parameter int             W     = 32,
   parameter int             FRAC  = 29,
   parameter int             N_MAX = 7,
   parameter int             ACC_W = 40,
   parameter logic [W-1:0]   EPS   = 32'h0000_0400
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a_diag,
   input  logic [2:0]   n_terms,
   input  logic         l_valid,
   input  logic [W-1:0] l_val,
   output logic         l_ready,
   output logic         busy,
   output logic [W-1:0] out_val,
   output logic         out_valid,
   output logic         pd_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam int          SQ_W    = 2*W - FRAC;
   localparam logic [2:0]  N_MAX_C = 3'(N_MAX);

   // Floor of the clamp; a zero floor reproduces the plain clamp-to-zero behaviour.
`ifdef CHOL_DIAG_EPS_EN
   localparam logic [W-1:0] FLOOR = EPS;
`else
   localparam logic [W-1:0] FLOOR = EPS & {W{1'b0}};
`endif

   state_t              state_r, state_s;
   logic [W-1:0]        a_r;
   logic [2:0]          n_r, cnt_r, n_eff_s, cnt_nxt_s;
   logic [ACC_W-1:0]    acc_r;
   logic [SQ_W-1:0]     prod_r;
   logic                prod_v_r;
   logic                l_ready_r, busy_r, out_valid_r, pd_err_r;
   logic [W-1:0]        out_val_r;
   logic                accept_s, last_s;
   logic signed [2*W-1:0] l_ext_s, l_sq_s;
   logic signed [ACC_W:0] diff_s, floor_ext_s;
   logic                nonpos_s, unused_s;
   logic [W-1:0]        clamp_val_s;

   assign n_eff_s   = (int'(n_terms) > N_MAX) ? N_MAX_C : n_terms;
   assign accept_s  = (state_r == ACC) && l_valid && l_ready_r;
   assign cnt_nxt_s = cnt_r + 3'd1;
   assign last_s    = accept_s && (cnt_nxt_s == n_r);

   // Square is non-negative, so the arithmetic shift reduces to dropping the low FRAC bits.
   assign l_ext_s   = {{W{l_val[W-1]}}, l_val};
   assign l_sq_s    = l_ext_s * l_ext_s;
   assign unused_s  = ^l_sq_s[FRAC-1:0];

   assign diff_s      = {{(ACC_W+1-W){a_r[W-1]}}, a_r} - {1'b0, acc_r};
   assign floor_ext_s = {{(ACC_W+1-W){1'b0}}, FLOOR};
   assign nonpos_s    = diff_s[ACC_W] || (diff_s == {(ACC_W+1){1'b0}});

   // Residual clamp: anything below the floor is replaced by the floor.
   always_comb begin
      clamp_val_s = diff_s[W-1:0];
      if (diff_s < floor_ext_s) begin
         clamp_val_s = FLOOR;
      end else begin
         clamp_val_s = diff_s[W-1:0];
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = (n_eff_s != 3'd0) ? ACC : DRAIN;
            end else begin
               state_s = IDLE;
            end
         end
         ACC: begin
            if (last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = ACC;
            end
         end
         DRAIN:   state_s = OUT;
         OUT:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Accumulation datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r         <= {W{1'b0}};
         n_r         <= 3'd0;
         cnt_r       <= 3'd0;
         acc_r       <= {ACC_W{1'b0}};
         prod_r      <= {SQ_W{1'b0}};
         prod_v_r    <= 1'b0;
         l_ready_r   <= 1'b0;
         busy_r      <= 1'b0;
         out_val_r   <= {W{1'b0}};
         out_valid_r <= 1'b0;
         pd_err_r    <= 1'b0;
      end else begin
         if ((state_r == IDLE) && start) begin
            a_r   <= a_diag;
            n_r   <= n_eff_s;
            cnt_r <= 3'd0;
            acc_r <= {ACC_W{1'b0}};
         end else if (prod_v_r) begin
            acc_r <= acc_r + {{(ACC_W-SQ_W){1'b0}}, prod_r};
         end
         if (accept_s) begin
            prod_r <= l_sq_s[2*W-1:FRAC];
            cnt_r  <= cnt_nxt_s;
         end
         prod_v_r    <= accept_s;
         l_ready_r   <= (state_s == ACC);
         busy_r      <= (state_s != IDLE);
         out_valid_r <= (state_r == OUT);
         if (state_r == OUT) begin
            out_val_r <= clamp_val_s;
            pd_err_r  <= nonpos_s;
         end
      end
   end

   assign l_ready   = l_ready_r;
   assign busy      = busy_r;
   assign out_val   = out_val_r;
   assign out_valid = out_valid_r;
   assign pd_err    = pd_err_r;

endmodule

// File: tb/tb_chol_diag_acc.sv
// Scoreboard bench for chol_diag_acc: directed pivots plus randomized pivots vs. an arithmetic model.
module tb_chol_diag_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a_diag = 32'd0;
   logic [2:0]  n_terms = 3'd0;
   logic        l_valid = 1'b0;
   logic [31:0] l_val = 32'd0;
   logic        l_ready, busy, out_valid, pd_err;
   logic [31:0] out_val;

   chol_diag_acc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_diag(a_diag), .n_terms(n_terms),
      .l_valid(l_valid), .l_val(l_val), .l_ready(l_ready), .busy(busy),
      .out_val(out_val), .out_valid(out_valid), .pd_err(pd_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] val;
      logic        err;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          outs = 0;
   int          pushes = 0;
   logic [31:0] tv[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: residual = a - sum(floor(l^2 / 2^29)), then clamp.
   task automatic model(input logic [31:0] a, input int n, output logic [31:0] v, output logic e);
      longint sum = 0;
      longint d, s, fl;
      for (int i = 0; i < n; i++) begin
         s = longint'($signed(tv[i]));
         sum += (s * s) >>> 29;
      end
      d = longint'($signed(a)) - sum;
`ifdef CHOL_DIAG_EPS_EN
      fl = 1024;
`else
      fl = 0;
`endif
      v = (d < fl) ? 32'(fl) : 32'(d);
      e = (d <= 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid) begin
         outs++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_val %0h with no pending pivot", out_val);
         end else begin
            e = sb.pop_front();
            chk("out_val", out_val, e.val);
            chk("pd_err", pd_err, e.err);
            chk("latency_edge", cyc, e.at);
         end
      end
   end

   task automatic run_pivot(input logic [31:0] a, input int n, input int gap, input bit rgap,
                            input bit poke, input bit use_x, input logic [31:0] xv, input bit xe);
      exp_t        e;
      int          guard;
      int          g;
      int unsigned last;
      bit          saw_ready = 1'b0;
      if (use_x) begin
         e.val = xv;
         e.err = xe;
      end else begin
         model(a, n, e.val, e.err);
      end
      @(negedge clk);
      start = 1'b1; a_diag = a; n_terms = 3'(n);
      @(negedge clk);
      start = 1'b0;
      last = cyc;
      for (int i = 0; i < n; i++) begin
         g = rgap ? int'($urandom_range(0, 2)) : gap;
         if (i > 0) begin
            repeat (g) begin
               l_valid = 1'b0;
               @(negedge clk);
            end
         end
         l_valid = 1'b1;
         l_val = tv[i];
         if (poke && i == 1) begin
            start = 1'b1;
            a_diag = 32'h1234_5678;
            n_terms = 3'd1;
         end
         guard = 0;
         while (!l_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (!l_ready) begin
            chk("l_ready_timeout", 64'(l_ready), 64'd1);
            break;
         end
         @(negedge clk);
         start = 1'b0;
         last = cyc;
      end
      l_valid = 1'b0;
      e.at = last + 2;
      sb.push_back(e);
      pushes++;
      guard = 0;
      while (busy && guard < 60) begin
         if (l_ready) saw_ready = 1'b1;
         @(negedge clk);
         guard++;
      end
      chk("busy_release", 64'(busy), 64'd0);
      if (n == 0) chk("l_ready_n0", 64'(saw_ready), 64'd0);
      @(negedge clk);
      chk("pd_err_hold", 64'(pd_err), 64'(e.err));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_val", out_val, 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_pd_err", 64'(pd_err), 64'd0);
      chk("rst_l_ready", 64'(l_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      tv[0] = 32'h1000_0000; tv[1] = 32'h1000_0000;
      run_pivot(32'h4000_0000, 2, 0, 1'b0, 1'b0, 1'b1, 32'h3000_0000, 1'b0);

      run_pivot(32'h2000_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 1'b0);

      tv[0] = 32'h2000_0000;
`ifdef CHOL_DIAG_EPS_EN
      run_pivot(32'h1000_0000, 1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b1);
`else
      run_pivot(32'h1000_0000, 1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
`endif

      repeat (3) begin
         @(negedge clk);
         l_valid = 1'b1;
         l_val = $urandom;
      end
      for (int i = 0; i < 3; i++) tv[i] = 32'hF000_0000;
      run_pivot(32'h4000_0000, 3, 2, 1'b0, 1'b0, 1'b1, 32'h2800_0000, 1'b0);

      for (int i = 0; i < 3; i++) tv[i] = 32'h0800_0000;
      @(negedge clk);
      start = 1'b1; a_diag = 32'h4000_0000; n_terms = 3'd3;
      @(negedge clk);
      start = 1'b0; l_valid = 1'b1; l_val = tv[0];
      @(negedge clk);
      l_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_l_ready", 64'(l_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      tv[0] = 32'h1000_0000; tv[1] = 32'h1000_0000;
      run_pivot(32'h4000_0000, 2, 0, 1'b0, 1'b0, 1'b1, 32'h3000_0000, 1'b0);

      for (int i = 0; i < 7; i++) tv[i] = 32'h8000_0000;
      run_pivot(32'h7FFF_FFFF, 7, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1);

      repeat (30) begin
         int n;
         n = int'($urandom_range(0, 7));
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) tv[i] = $urandom;
            else tv[i] = $urandom & 32'h0FFF_FFFF;
            if ($urandom_range(0, 3) == 0) tv[i] = ~tv[i] + 32'd1;
         end
         run_pivot($urandom, n, 0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 64'(sb.size()), 64'd0);
      chk("out_count", 64'(outs), 64'(pushes));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
